// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the NPC write-back stage: FSM state encoding and index widths.
package ysyx_23060187_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_NOTIFY = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/ysyx_23060187_wbu_regfile_if.sv
// Bundle of the EXU->WBU result handshake, WBU->IFU next-PC handshake, IDU read ports and hazard info.
interface ysyx_23060187_wbu_regfile_if
  import ysyx_23060187_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic                 exu_wbu_valid;
  logic                 wbu_exu_ready;
  logic [REG_IDX_W-1:0] exu_wbu_rd;
  logic                 exu_wbu_wen;
  logic [XLEN-1:0]      exu_wbu_wdata;
  logic [XLEN-1:0]      exu_wbu_dnpc;
  logic                 wbu_ifu_valid;
  logic                 ifu_wbu_ready;
  logic [XLEN-1:0]      wbu_ifu_dnpc;
  logic [REG_IDX_W-1:0] idu_raddr1;
  logic [REG_IDX_W-1:0] idu_raddr2;
  logic [XLEN-1:0]      idu_rdata1;
  logic [XLEN-1:0]      idu_rdata2;
  logic                 wbu_pend_valid;
  logic [REG_IDX_W-1:0] wbu_pend_rd;

  // Surrounding pipeline (EXU, IFU, IDU) side
  modport master (
    output exu_wbu_valid, exu_wbu_rd, exu_wbu_wen, exu_wbu_wdata, exu_wbu_dnpc,
    output ifu_wbu_ready, idu_raddr1, idu_raddr2,
    input  wbu_exu_ready, wbu_ifu_valid, wbu_ifu_dnpc, idu_rdata1, idu_rdata2,
    input  wbu_pend_valid, wbu_pend_rd
  );

  modport slave (
    input  exu_wbu_valid, exu_wbu_rd, exu_wbu_wen, exu_wbu_wdata, exu_wbu_dnpc,
    input  ifu_wbu_ready, idu_raddr1, idu_raddr2,
    output wbu_exu_ready, wbu_ifu_valid, wbu_ifu_dnpc, idu_rdata1, idu_rdata2,
    output wbu_pend_valid, wbu_pend_rd
  );
endinterface

// File: rtl/ysyx_23060187_gpr.sv
// General-purpose register array: one synchronous write port, two combinational read ports,
// x0 and out-of-range indices read as zero, asynchronous active-low clear.
module ysyx_23060187_gpr
  import ysyx_23060187_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [XLEN-1:0]      rdata1,
  output logic [XLEN-1:0]      rdata2
);
  localparam int IDX_W = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];

  // Caller already masks x0 and out-of-range writes into we
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0 || 32'(raddr1) >= NREG) ? '0 : regs[raddr1[IDX_W-1:0]];
  assign rdata2 = (raddr2 == '0 || 32'(raddr2) >= NREG) ? '0 : regs[raddr2[IDX_W-1:0]];

endmodule

// File: rtl/ysyx_23060187_wbu_regfile.sv
// NPC write-back unit: IDLE -> WRITE -> NOTIFY, commits EXU results to the GPRs, then hands dnpc to IFU.
// Optional retired-instruction counter wbu_instret under `YSYX_23060187_WBU_INSTRET_EN.
module ysyx_23060187_wbu_regfile
  import ysyx_23060187_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32
) (
  input  logic clk,
  input  logic rst,
  ysyx_23060187_wbu_regfile_if.slave bus
`ifdef YSYX_23060187_WBU_INSTRET_EN
  , output logic [63:0] wbu_instret
`endif
);
  wbu_state_e           state;
  logic [REG_IDX_W-1:0] rd_q;
  logic                 wen_q;
  logic [XLEN-1:0]      wdata_q;
  logic [XLEN-1:0]      dnpc_q;
  logic                 commit_en;
  logic                 gpr_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      rd_q   <= '0;
      wen_q  <= 1'b0;
      dnpc_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.exu_wbu_valid) begin
            rd_q   <= bus.exu_wbu_rd;
            wen_q  <= bus.exu_wbu_wen;
            dnpc_q <= bus.exu_wbu_dnpc;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE:  state <= ST_NOTIFY;
        ST_NOTIFY: if (bus.ifu_wbu_ready) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Write data is only consumed after a handshake, so it needs no reset
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.exu_wbu_valid) wdata_q <= bus.exu_wbu_wdata;
  end

  assign commit_en = wen_q && (rd_q != '0) && (32'(rd_q) < NREG);
  assign gpr_we    = (state == ST_WRITE) && commit_en;

  assign bus.wbu_exu_ready  = (state == ST_IDLE);
  assign bus.wbu_ifu_valid  = (state == ST_NOTIFY);
  assign bus.wbu_ifu_dnpc   = dnpc_q;
  assign bus.wbu_pend_valid = gpr_we;
  assign bus.wbu_pend_rd    = (state == ST_WRITE) ? rd_q : '0;

  ysyx_23060187_gpr #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_gpr (
    .clk    (clk),
    .rst    (rst),
    .we     (gpr_we),
    .waddr  (rd_q),
    .wdata  (wdata_q),
    .raddr1 (bus.idu_raddr1),
    .raddr2 (bus.idu_raddr2),
    .rdata1 (bus.idu_rdata1),
    .rdata2 (bus.idu_rdata2)
  );

`ifdef YSYX_23060187_WBU_INSTRET_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wbu_instret <= '0;
    else if (state == ST_NOTIFY && bus.ifu_wbu_ready) wbu_instret <= wbu_instret + 64'd1;
  end
`endif

endmodule
